// File: rtl/axis_demux_n.sv
// rtl/axis_demux_n.sv - packet-safe registered 1:N AXI-stream demultiplexer with drop route
module axis_demux_n #(
    parameter int DW     = 512,
    parameter int NPORTS = 4,
    parameter int SELW   = $clog2(NPORTS) + 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [SELW-1:0]      port_select,
    output logic                 busy,
    output logic [NPORTS-1:0]    packet_strb,
    output logic                 drop_strb,
    input  logic [DW-1:0]        axis_in_tdata,
    input  logic                 axis_in_tlast,
    input  logic                 axis_in_tvalid,
    output logic                 axis_in_tready,
    output logic [NPORTS*DW-1:0] axis_out_tdata,
    output logic [NPORTS-1:0]    axis_out_tlast,
    output logic [NPORTS-1:0]    axis_out_tvalid,
    input  logic [NPORTS-1:0]    axis_out_tready
);

    logic              r_busy;
    logic [SELW-1:0]   r_lock_sel;
    logic              r_out_valid;
    logic [DW-1:0]     r_out_data;
    logic              r_out_last;
    logic [SELW-1:0]   r_dest;
    logic [NPORTS-1:0] r_packet_strb;
    logic              r_drop_strb;

    logic [SELW-1:0]   w_route;
    logic              w_drop;
    logic [NPORTS-1:0] w_dest_oh;
    logic              w_dest_ready;
    logic              w_unload;
    logic              w_accept;
    logic              w_load;

    // The route is frozen while a packet is in flight so a select change cannot split it.
    assign w_route = r_busy ? r_lock_sel : port_select;
    assign w_drop  = (w_route >= SELW'(NPORTS));

    always_comb begin
        w_dest_oh = '0;
        for (int p = 0; p < NPORTS; p++) begin
            w_dest_oh[p] = (r_dest == SELW'(p));
        end
    end

    assign w_dest_ready   = |(w_dest_oh & axis_out_tready);
    assign w_unload       = r_out_valid & w_dest_ready;
    assign axis_in_tready = w_drop | ~r_out_valid | w_dest_ready;
    assign w_accept       = axis_in_tvalid & axis_in_tready;
    assign w_load         = w_accept & ~w_drop;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_busy        <= 1'b0;
            r_out_valid   <= 1'b0;
            r_packet_strb <= '0;
            r_drop_strb   <= 1'b0;
        end else begin
            if (w_accept) begin
                if (!r_busy && !axis_in_tlast) begin
                    r_busy <= 1'b1;
                end else if (r_busy && axis_in_tlast) begin
                    r_busy <= 1'b0;
                end
            end
            if (w_load) begin
                r_out_valid <= 1'b1;
            end else if (w_unload) begin
                r_out_valid <= 1'b0;
            end
            r_packet_strb <= w_dest_oh & axis_out_tready & {NPORTS{r_out_valid & r_out_last}};
            r_drop_strb   <= w_accept & w_drop & axis_in_tlast;
        end
    end

    // Payload and route capture need no reset; they are qualified by r_out_valid / r_busy.
    always_ff @(posedge clk) begin
        if (w_accept && !r_busy && !axis_in_tlast) begin
            r_lock_sel <= port_select;
        end
        if (w_load) begin
            r_out_data <= axis_in_tdata;
            r_out_last <= axis_in_tlast;
            r_dest     <= w_route;
        end
    end

    assign busy            = r_busy;
    assign packet_strb     = r_packet_strb;
    assign drop_strb       = r_drop_strb;
    assign axis_out_tdata  = {NPORTS{r_out_data}};
    assign axis_out_tvalid = w_dest_oh & {NPORTS{r_out_valid}};
    assign axis_out_tlast  = w_dest_oh & {NPORTS{r_out_valid & r_out_last}};

endmodule

// File: tb/tb_axis_demux_n.sv
// tb/tb_axis_demux_n.sv - scoreboard bench for axis_demux_n
module tb_axis_demux_n;

    localparam int DW = 32;
    localparam int NP = 4;
    localparam int SW = 3;

    typedef struct {
        int          port;
        logic [DW-1:0] data;
        logic        last;
    } ent_t;

    logic             clk = 1'b0;
    logic             resetn;
    logic [SW-1:0]    port_select;
    logic             busy;
    logic [NP-1:0]    packet_strb;
    logic             drop_strb;
    logic [DW-1:0]    in_tdata;
    logic             in_tlast;
    logic             in_tvalid;
    logic             in_tready;
    logic [NP*DW-1:0] out_tdata;
    logic [NP-1:0]    out_tlast;
    logic [NP-1:0]    out_tvalid;
    logic [NP-1:0]    out_tready;

    int n_tests = 0;
    int n_fail  = 0;

    ent_t sb[$];
    logic          m_busy = 1'b0;
    logic [SW-1:0] m_lock = '0;
    logic [NP-1:0] pend_pkt = '0;
    logic          pend_drop = 1'b0;
    logic          lat_pend = 1'b0;
    int            lat_port = 0;
    logic [DW-1:0] lat_data = '0;
    logic          hold = 1'b0;
    int            hold_port = 0;
    logic [DW-1:0] hold_data = '0;
    logic          rst_q = 1'b0;
    int            recv[NP];
    int            pkt_cnt[NP];
    int            drop_cnt = 0;
    logic          bp_en = 1'b0;
    int            bp_i = 0;
    logic [3:0]    bp_pat = 4'b1001;

    axis_demux_n #(.DW(DW), .NPORTS(NP), .SELW(SW)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .port_select     (port_select),
        .busy            (busy),
        .packet_strb     (packet_strb),
        .drop_strb       (drop_strb),
        .axis_in_tdata   (in_tdata),
        .axis_in_tlast   (in_tlast),
        .axis_in_tvalid  (in_tvalid),
        .axis_in_tready  (in_tready),
        .axis_out_tdata  (out_tdata),
        .axis_out_tlast  (out_tlast),
        .axis_out_tvalid (out_tvalid),
        .axis_out_tready (out_tready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Port 0 ready follows 1,0,0,1 while backpressure is enabled; other ports always ready.
    initial begin
        out_tready = '1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) begin
                out_tready = {3'b111, bp_pat[bp_i % 4]};
                bp_i++;
            end else begin
                out_tready = '1;
            end
        end
    end

    always @(posedge clk) rst_q = ~resetn;

    always @(negedge clk) begin
        logic [SW-1:0] route;
        logic          exp_rdy;
        logic [NP-1:0] hs;
        logic [NP-1:0] nxt_pkt;
        logic          nxt_drop;
        ent_t          e;
        route = m_busy ? m_lock : port_select;
        if (rst_q) begin
            check("rst_tvalid", 64'(out_tvalid), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_pkt_strb", 64'(packet_strb), 64'd0);
            check("rst_drop_strb", 64'(drop_strb), 64'd0);
        end else begin
            check("busy", 64'(busy), 64'(m_busy));
            check("pkt_strb", 64'(packet_strb), 64'(pend_pkt));
            check("drop_strb", 64'(drop_strb), 64'(pend_drop));
            check("onehot", 64'($countones(out_tvalid) <= 1), 64'd1);
            if (lat_pend) begin
                check("lat_valid", 64'(out_tvalid[lat_port]), 64'd1);
                check("lat_data", 64'(out_tdata[lat_port*DW +: DW]), 64'(lat_data));
            end
            if (hold) begin
                check("hold_valid", 64'(out_tvalid[hold_port]), 64'd1);
                check("hold_data", 64'(out_tdata[hold_port*DW +: DW]), 64'(hold_data));
            end
            exp_rdy = (route >= SW'(NP)) || (out_tvalid == '0) || ((out_tvalid & out_tready) != '0);
            check("in_tready", 64'(in_tready), 64'(exp_rdy));
        end
        if (!resetn) begin
            sb.delete();
            m_busy    = 1'b0;
            pend_pkt  = '0;
            pend_drop = 1'b0;
            lat_pend  = 1'b0;
            hold      = 1'b0;
        end else begin
            for (int p = 0; p < NP; p++) if (packet_strb[p]) pkt_cnt[p]++;
            if (drop_strb) drop_cnt++;
            hs      = out_tvalid & out_tready;
            nxt_pkt = hs & out_tlast;
            hold    = 1'b0;
            for (int p = 0; p < NP; p++) begin
                if (out_tvalid[p] && !out_tready[p]) begin
                    hold      = 1'b1;
                    hold_port = p;
                    hold_data = out_tdata[p*DW +: DW];
                end
                if (hs[p]) begin
                    recv[p]++;
                    if (sb.size() == 0) begin
                        check("sb_underflow", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check("out_port", 64'(p), 64'(e.port));
                        check("out_data", 64'(out_tdata[p*DW +: DW]), 64'(e.data));
                        check("out_last", 64'(out_tlast[p]), 64'(e.last));
                    end
                end
            end
            nxt_drop = 1'b0;
            lat_pend = 1'b0;
            if (in_tvalid && in_tready) begin
                if (route < SW'(NP)) begin
                    sb.push_back('{port: int'(route), data: in_tdata, last: in_tlast});
                    lat_pend = 1'b1;
                    lat_port = int'(route);
                    lat_data = in_tdata;
                end else if (in_tlast) begin
                    nxt_drop = 1'b1;
                end
                if (!m_busy && !in_tlast) begin
                    m_busy = 1'b1;
                    m_lock = port_select;
                end else if (m_busy && in_tlast) begin
                    m_busy = 1'b0;
                end
            end
            pend_pkt  = nxt_pkt;
            pend_drop = nxt_drop;
        end
    end

    task automatic send_beat(input logic [SW-1:0] sel, input logic [DW-1:0] d, input logic l);
        int   budget;
        logic acc;
        budget      = 200;
        acc         = 1'b0;
        port_select = sel;
        in_tdata    = d;
        in_tlast    = l;
        in_tvalid   = 1'b1;
        while (!acc && budget > 0) begin
            @(negedge clk);
            acc = in_tready;
            @(posedge clk);
            #1;
            budget--;
        end
        if (!acc) check("send_timeout", 64'd0, 64'd1);
        in_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input logic [SW-1:0] sel, input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) send_beat(sel, base + DW'(i), i == n - 1);
    endtask

    task automatic drain();
        int budget;
        budget = 300;
        while (sb.size() != 0 && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (budget == 0) check("drain_timeout", 64'(sb.size()), 64'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_counts();
        for (int p = 0; p < NP; p++) begin
            recv[p]    = 0;
            pkt_cnt[p] = 0;
        end
        drop_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_counts();
        resetn      = 1'b0;
        in_tvalid   = 1'b1;
        in_tlast    = 1'b0;
        in_tdata    = 32'hDEAD_BEEF;
        port_select = '0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("t1_tvalid", 64'(out_tvalid), 64'd0);
        check("t1_busy", 64'(busy), 64'd0);
        in_tvalid = 1'b0;
        resetn    = 1'b1;
        @(posedge clk);
        #1;

        clear_counts();
        send_pkt(3'd2, 4, 32'hA0);
        drain();
        check("t2_recv2", 64'(recv[2]), 64'd4);
        check("t2_recv_other", 64'(recv[0] + recv[1] + recv[3]), 64'd0);
        check("t2_pkt2", 64'(pkt_cnt[2]), 64'd1);
        check("t2_pkt_other", 64'(pkt_cnt[0] + pkt_cnt[1] + pkt_cnt[3]), 64'd0);

        clear_counts();
        send_beat(3'd1, 32'hB0, 1'b0);
        send_beat(3'd1, 32'hB1, 1'b0);
        port_select = 3'd3;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        send_beat(3'd3, 32'hB2, 1'b0);
        send_beat(3'd3, 32'hB3, 1'b0);
        send_beat(3'd3, 32'hB4, 1'b1);
        send_pkt(3'd3, 2, 32'hC0);
        drain();
        check("t3_recv1", 64'(recv[1]), 64'd5);
        check("t3_recv3", 64'(recv[3]), 64'd2);
        check("t3_pkt1", 64'(pkt_cnt[1]), 64'd1);

        clear_counts();
        bp_i  = 0;
        bp_en = 1'b1;
        send_pkt(3'd0, 6, 32'hD0);
        drain();
        bp_en = 1'b0;
        check("t4_recv0", 64'(recv[0]), 64'd6);
        check("t4_pkt0", 64'(pkt_cnt[0]), 64'd1);

        clear_counts();
        send_pkt(3'd4, 3, 32'hE0);
        send_pkt(3'd0, 2, 32'hF0);
        send_pkt(3'd7, 1, 32'hF8);
        drain();
        check("t5_drop", 64'(drop_cnt), 64'd2);
        check("t5_recv0", 64'(recv[0]), 64'd2);
        check("t5_recv_other", 64'(recv[1] + recv[2] + recv[3]), 64'd0);

        clear_counts();
        send_beat(3'd2, 32'h10, 1'b0);
        send_beat(3'd2, 32'h11, 1'b0);
        resetn = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_tvalid", 64'(out_tvalid), 64'd0);
        resetn = 1'b1;
        send_pkt(3'd3, 2, 32'h20);
        drain();
        check("t6_recv3", 64'(recv[3]), 64'd2);
        check("t6_recv2", 64'(recv[2]), 64'd1);
        check("t6_pkt3", 64'(pkt_cnt[3]), 64'd1);
        check("t6_pkt2", 64'(pkt_cnt[2]), 64'd0);

        check("sb_final", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
